uart_tx_buffered: RTL and testbench

Buffered UART transmit path: a small FIFO in front of an 8N1 serializer. It sits between the memory-mapped IO interface and the FPGA serial output pin. A store to the transmit-data address is pushed in via a ready/valid handshake, and the block drives the serial line autonomously. `DataInReady` and `TxBusy` feed the IO interface's status word, so software can poll before writing.

---
 rtl/uart_tx_buffered_if.sv | 9 +
 rtl/uart_tx_buffered.sv | 103 ++++++++++
 tb/tb_uart_tx_buffered.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_buffered_if.sv
// Byte-push handshake between the IO register file and the buffered UART transmitter.
interface uart_tx_buffered_if;
    logic [7:0] DataIn;
    logic       DataInValid;
    logic       DataInReady;

    modport master (output DataIn, output DataInValid, input DataInReady);
    modport slave  (input DataIn, input DataInValid, output DataInReady);
endinterface

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: a small circular FIFO feeding a two-state serializer
// that chains frames back to back while bytes remain queued.
module uart_tx_buffered #(
    parameter int ClockFreq = 100_000_000,
    parameter int BaudRate  = 115_200,
    parameter int Depth     = 4
) (
    input  logic                  Clock,
    input  logic                  Reset,
    uart_tx_buffered_if.slave     tx,
    output logic                  SOut,
    output logic                  TxBusy,
    output logic [$clog2(Depth):0] Count
);
    localparam int SymbolEdgeTime = ClockFreq / BaudRate;
    localparam int AW = $clog2(Depth);
    localparam int CW = (SymbolEdgeTime > 1) ? $clog2(SymbolEdgeTime) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [7:0]    mem [Depth];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [0:0]    state;
    logic [9:0]    shift;
    logic [3:0]    bit_idx;
    logic [CW-1:0] cyc;
    logic          full, nonempty, push, pop, sym_wrap, frame_end;

    // Ready ignores a same-edge pop so a full FIFO never accepts a byte.
    assign full           = (count == (AW+1)'(Depth));
    assign nonempty       = (count != '0);
    assign tx.DataInReady = !full && !Reset;
    assign push           = tx.DataInValid && tx.DataInReady;
    assign sym_wrap       = (state == SEND) && (cyc == CW'(SymbolEdgeTime - 1));
    assign frame_end      = sym_wrap && (bit_idx == 4'd9);
    assign pop            = nonempty && ((state == IDLE) || frame_end);

    always_ff @(posedge Clock) begin
        if (push) mem[wr_ptr] <= tx.DataIn;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state   <= IDLE;
            shift   <= '1;
            bit_idx <= '0;
            cyc     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        shift   <= {1'b1, mem[rd_ptr], 1'b0};
                        bit_idx <= '0;
                        cyc     <= '0;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    if (sym_wrap) begin
                        cyc <= '0;
                        if (frame_end) begin
                            // Reload in place so the next start bit follows the stop bit directly.
                            if (pop) begin
                                shift   <= {1'b1, mem[rd_ptr], 1'b0};
                                bit_idx <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            shift   <= {1'b1, shift[9:1]};
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign SOut   = (state == SEND) ? shift[0] : 1'b1;
    assign TxBusy = (state == SEND) || nonempty;
    assign Count  = count;
endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed + randomized bench: line-level frame checks plus a mid-bit sampling receiver model.
module tb_uart_tx_buffered;
    localparam int SET   = 10;
    localparam int FRAME = 10 * SET;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       SOut, TxBusy;
    logic [2:0] Count;

    uart_tx_buffered_if bus();

    uart_tx_buffered #(.ClockFreq(1_000_000), .BaudRate(100_000), .Depth(4)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .tx    (bus),
        .SOut  (SOut),
        .TxBusy(TxBusy),
        .Count (Count)
    );

    always #5 Clock = ~Clock;

    int         n_chk = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    int         rx_err = 0;
    bit         rx_active = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_sh = '0;

    // Receiver: detect the falling start edge, sample each bit in its middle.
    always @(negedge Clock) begin
        if (Reset) begin
            rx_active <= 1'b0;
        end else if (!rx_active) begin
            if (SOut === 1'b0) begin
                rx_active <= 1'b1;
                rx_cnt    <= 1;
            end
        end else begin
            rx_cnt <= rx_cnt + 1;
            if (rx_cnt == 5 && SOut !== 1'b0) rx_err <= rx_err + 1;
            if (rx_cnt >= 15 && rx_cnt <= 85 && (rx_cnt % 10) == 5) rx_sh <= {SOut, rx_sh[7:1]};
            if (rx_cnt == 95) begin
                if (SOut === 1'b1) rx_q.push_back(rx_sh);
                else rx_err <= rx_err + 1;
            end
            if (rx_cnt == 99) rx_active <= 1'b0;
        end
    end

    function automatic logic exp_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
    endfunction

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (TxBusy !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        chk("drain_timeout", 32'(TxBusy), 0);
        repeat (2) tick();
    endtask

    task automatic check_rx(input string tag);
        chk({tag, "_rx_count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            chk({tag, "_rx_byte"}, 32'(rx_q[i]), 32'(exp_q[i]));
        rx_q.delete();
        exp_q.delete();
    endtask

    int n_acc;
    bit acc;

    task automatic fill_step();
        acc = bus.DataInReady;
        tick();
        if (acc) begin
            exp_q.push_back(bus.DataIn);
            bus.DataIn = bus.DataIn + 8'd1;
            n_acc++;
        end
    endtask

    initial begin
        bus.DataIn = '0;
        bus.DataInValid = 1'b0;
        Reset = 1'b1;
        repeat (3) tick();
        chk("rst_sout", 32'(SOut), 1);
        chk("rst_ready", 32'(bus.DataInReady), 0);
        chk("rst_busy", 32'(TxBusy), 0);
        chk("rst_count", 32'(Count), 0);
        Reset = 1'b0;
        #1;
        chk("rel_ready", 32'(bus.DataInReady), 1);
        tick();
        chk("rel_sout", 32'(SOut), 1);

        // Single byte, exact bit pattern and busy timing
        bus.DataIn = 8'hA5;
        bus.DataInValid = 1'b1;
        tick();
        bus.DataInValid = 1'b0;
        chk("lat_count1", 32'(Count), 1);
        chk("lat_sout_idle", 32'(SOut), 1);
        tick();
        chk("load_count0", 32'(Count), 0);
        for (int i = 0; i < FRAME; i++) begin
            chk("single_bit", 32'(SOut), 32'(exp_bit(8'hA5, i / SET)));
            chk("single_busy", 32'(TxBusy), 1);
            tick();
        end
        chk("single_busy_fall", 32'(TxBusy), 0);
        chk("single_sout_idle", 32'(SOut), 1);
        exp_q.push_back(8'hA5);
        check_rx("single");

        // Back-to-back frames, no idle gap
        bus.DataIn = 8'h55;
        bus.DataInValid = 1'b1;
        tick();
        bus.DataIn = 8'hAA;
        tick();
        bus.DataInValid = 1'b0;
        chk("b2b_count", 32'(Count), 1);
        for (int i = 0; i < 2 * FRAME; i++) begin
            chk("b2b_bit", 32'(SOut), 32'(exp_bit((i < FRAME) ? 8'h55 : 8'hAA, (i % FRAME) / SET)));
            tick();
        end
        chk("b2b_busy_fall", 32'(TxBusy), 0);
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hAA);
        check_rx("b2b");

        // Fill to full, then full-with-pop at the first frame end
        n_acc = 0;
        bus.DataIn = 8'h01;
        bus.DataInValid = 1'b1;
        repeat (10) fill_step();
        chk("fill_accepted", n_acc, 5);
        chk("fill_ready", 32'(bus.DataInReady), 0);
        chk("fill_count", 32'(Count), 4);
        repeat (91) fill_step();
        chk("full_hold_ready", 32'(bus.DataInReady), 0);
        chk("full_hold_acc", n_acc, 5);
        fill_step();
        chk("fullpop_acc", n_acc, 5);
        chk("fullpop_count", 32'(Count), 3);
        chk("fullpop_ready", 32'(bus.DataInReady), 1);
        chk("fullpop_start", 32'(SOut), 0);
        fill_step();
        chk("refill_acc", n_acc, 6);
        chk("refill_count", 32'(Count), 4);
        bus.DataInValid = 1'b0;
        drain(1000);
        check_rx("fill");

        // Reset during bit 4 with two bytes queued
        bus.DataInValid = 1'b1;
        bus.DataIn = 8'h3C;
        tick();
        bus.DataIn = 8'hC3;
        tick();
        bus.DataIn = 8'h99;
        tick();
        bus.DataInValid = 1'b0;
        repeat (44) tick();
        chk("mid_bit4", 32'(SOut), 32'(exp_bit(8'h3C, 4)));
        chk("mid_count", 32'(Count), 2);
        Reset = 1'b1;
        tick();
        chk("midrst_sout", 32'(SOut), 1);
        chk("midrst_count", 32'(Count), 0);
        chk("midrst_busy", 32'(TxBusy), 0);
        Reset = 1'b0;
        #1;
        for (int i = 0; i < 500; i++) begin
            chk("idle_sout", 32'(SOut), 1);
            chk("idle_ready", 32'(bus.DataInReady), 1);
            tick();
        end
        chk("idle_busy", 32'(TxBusy), 0);
        check_rx("midrst");

        // Random valid/data against the byte-order model
        begin
            int n, c;
            n = 0;
            c = 0;
            while (n < 24 && c < 6000) begin
                bus.DataInValid = 1'($urandom_range(0, 1));
                bus.DataIn = 8'($urandom);
                #1;
                chk("rand_ready", 32'(bus.DataInReady), 32'(Count != 3'd4));
                acc = bus.DataInValid && bus.DataInReady;
                tick();
                if (acc) begin
                    exp_q.push_back(bus.DataIn);
                    n++;
                end
                c++;
            end
            bus.DataInValid = 1'b0;
            chk("rand_accept_timeout", n, 24);
        end
        drain(24 * FRAME + 500);
        check_rx("rand");
        chk("rx_frame_errors", rx_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
